// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI write-channel scheduler.
//
// Contents:
//   wr_state_e          scheduler FSM states (IDLE, ARB, ADDR, DATA, RESP)
//   MAP_S               number of address-map entries (real slaves)
//   SLV_BASE / SLV_MASK per-slave base/mask; entry i is in bits [i*32 +: 32]
//   DEFAULT_SLV         route bit used when no region matches (DECERR slave)
//   TIMEOUT_CYC_MAX     largest supported watchdog limit
//   CNT_W               watchdog counter width
package axi_wr_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        RESP = 3'd4
    } wr_state_e;

    localparam int MAP_S = 5;

    // Each slave owns one 256 MB window; addresses at 0x5000_0000 and above
    // fall through to the default slave.
    localparam logic [MAP_S-1:0][31:0] SLV_BASE = {
        32'h4000_0000,
        32'h3000_0000,
        32'h2000_0000,
        32'h1000_0000,
        32'h0000_0000
    };

    localparam logic [MAP_S-1:0][31:0] SLV_MASK = {MAP_S{32'hF000_0000}};

    localparam int DEFAULT_SLV = MAP_S;

    localparam int TIMEOUT_CYC_MAX = 1024;
    localparam int CNT_W           = $clog2(TIMEOUT_CYC_MAX);

endpackage

// File: rtl/axi_wr_scheduler_rr_arbiter.sv
// Round-robin request picker (combinational). Searches upward from the
// pointer, wrapping, and returns the first active requester.
//
// Ports:
//   req    in  NUM_M   request vector
//   ptr    in  PTR_W   index that has highest priority this round
//   grant  out NUM_M   one-hot winner, 0 when no request
//   idx    out PTR_W   binary index of the winner, 0 when no request
module rr_arbiter #(
    parameter int NUM_M = 2,
    parameter int PTR_W = 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NUM_M-1:0] grant,
    output logic [PTR_W-1:0] idx
);

    always_comb begin
        logic found;
        int   j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_M; i++) begin
            j = (int'(ptr) + i) % NUM_M;
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_scheduler.sv
// Write-channel scheduler for the AXI bridge. Picks one master's AW request
// (round-robin), decodes its address to a slave route and holds that route
// through the AW, W and B phases. One write in flight at a time.
//
// Ports:
//   ACLK, ARESET           clock, synchronous active-high reset
//   aw_valid_m / aw_addr_m per-master AWVALID / AWADDR (master 0 in LSBs)
//   route_awready          AWREADY of the routed slave
//   route_wvalid/wready/wlast, route_bvalid/bready  routed W/B handshakes
//   err_clr                clears err_timeout
//   grant_m                one-hot granted master (0 when idle)
//   route_slave            one-hot target, bit NUM_S = default slave
//   aw_en, w_en, b_en      routing-mux enables for each phase
//   busy                   any state other than IDLE
//   err_timeout            sticky watchdog flag
//
// Optional feature: define AXI_WR_TIMEOUT_EN to enable the DATA/RESP
// watchdog. Without it err_timeout is constant 0 and err_clr is ignored.
// The address map lives in axi_wr_pkg and covers up to MAP_S slaves with
// ADDR_W up to 32.
module axi_wr_scheduler
    import axi_wr_pkg::*;
#(
    parameter int NUM_M       = 2,
    parameter int NUM_S       = 5,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [NUM_M-1:0]        aw_valid_m,
    input  logic [NUM_M*ADDR_W-1:0] aw_addr_m,
    input  logic                    route_awready,
    input  logic                    route_wvalid,
    input  logic                    route_wready,
    input  logic                    route_wlast,
    input  logic                    route_bvalid,
    input  logic                    route_bready,
    input  logic                    err_clr,
    output logic [NUM_M-1:0]        grant_m,
    output logic [NUM_S:0]          route_slave,
    output logic                    aw_en,
    output logic                    w_en,
    output logic                    b_en,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    wr_state_e          state, state_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic [PTR_W-1:0]   gidx, gidx_n;
    logic [PTR_W-1:0]   arb_idx;
    logic [NUM_M-1:0]   arb_grant, grant_n;
    logic [NUM_S:0]     route_n;
    logic [ADDR_W-1:0]  arb_addr;
    logic               aw_hs, w_hs, b_hs;
    logic               timeout_hit;

    // Lowest-numbered matching region wins, hence the descending scan that
    // lets lower indices overwrite higher ones.
    function automatic logic [NUM_S:0] decode(input logic [ADDR_W-1:0] a);
        logic [NUM_S:0] r;
        r        = '0;
        r[NUM_S] = 1'b1;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if ((a & SLV_MASK[i][ADDR_W-1:0]) == SLV_BASE[i][ADDR_W-1:0]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] g);
        if (int'(g) == NUM_M - 1) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_M (NUM_M),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (aw_valid_m),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign arb_addr = aw_addr_m[int'(arb_idx) * ADDR_W +: ADDR_W];

    assign aw_hs = aw_valid_m[gidx] && route_awready;
    assign w_hs  = route_wvalid && route_wready;
    assign b_hs  = route_bvalid && route_bready;

`ifdef AXI_WR_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    // A handshake in the limit cycle counts as progress, not as a timeout.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1)) &&
                         (((state == DATA) && !w_hs) || ((state == RESP) && !b_hs));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt <= '0;
        end else if ((state != DATA) && (state_n == DATA)) begin
            cnt <= '0;
        end else if ((state == DATA) && w_hs) begin
            cnt <= '0;
        end else if ((state == DATA) || (state == RESP)) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            err_timeout <= 1'b0;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end else if (timeout_hit) begin
            err_timeout <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_cfg  = &{1'b0, err_clr, (TIMEOUT_CYC > 0)};
`endif

    always_comb begin
        state_n = state;
        grant_n = grant_m;
        route_n = route_slave;
        gidx_n  = gidx;
        ptr_n   = ptr;

        case (state)
            IDLE: begin
                if (|aw_valid_m) begin
                    state_n = ARB;
                    grant_n = arb_grant;
                    route_n = decode(arb_addr);
                    gidx_n  = arb_idx;
                end
            end
            ARB:  state_n = ADDR;
            ADDR: if (aw_hs) state_n = DATA;
            DATA: if (w_hs && route_wlast) state_n = RESP;
            RESP: if (b_hs) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (timeout_hit) begin
            state_n = IDLE;
        end

        // Leaving a transaction, by completion or by watchdog, drops the
        // route and moves priority past the master just served.
        if ((state != IDLE) && (state_n == IDLE)) begin
            grant_n = '0;
            route_n = '0;
            ptr_n   = ptr_after(gidx);
        end
    end

    // Enables and busy are registered copies of the next state so every
    // output changes only on the clock edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= IDLE;
            ptr         <= '0;
            gidx        <= '0;
            grant_m     <= '0;
            route_slave <= '0;
            aw_en       <= 1'b0;
            w_en        <= 1'b0;
            b_en        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            gidx        <= gidx_n;
            grant_m     <= grant_n;
            route_slave <= route_n;
            aw_en       <= (state_n == ADDR);
            w_en        <= (state_n == DATA);
            b_en        <= (state_n == RESP);
            busy        <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_axi_wr_scheduler.sv
// Scoreboard bench for axi_wr_scheduler: masters and the routed slave are
// modelled here; the expected grant/route for each write is queued when the
// write is requested and checked when the DUT opens the AW phase.
module tb_axi_wr_scheduler;

    localparam int NUM_M  = 2;
    localparam int NUM_S  = 5;
    localparam int ADDR_W = 32;
    localparam int TO_CYC = 16;

    logic                    ACLK;
    logic                    ARESET;
    logic [NUM_M-1:0]        aw_valid_m;
    logic [NUM_M*ADDR_W-1:0] aw_addr_m;
    logic                    route_awready, route_wvalid, route_wready, route_wlast;
    logic                    route_bvalid, route_bready, err_clr;
    logic [NUM_M-1:0]        grant_m;
    logic [NUM_S:0]          route_slave;
    logic                    aw_en, w_en, b_en, busy, err_timeout;

    axi_wr_scheduler #(
        .NUM_M       (NUM_M),
        .NUM_S       (NUM_S),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .aw_valid_m    (aw_valid_m),
        .aw_addr_m     (aw_addr_m),
        .route_awready (route_awready),
        .route_wvalid  (route_wvalid),
        .route_wready  (route_wready),
        .route_wlast   (route_wlast),
        .route_bvalid  (route_bvalid),
        .route_bready  (route_bready),
        .err_clr       (err_clr),
        .grant_m       (grant_m),
        .route_slave   (route_slave),
        .aw_en         (aw_en),
        .w_en          (w_en),
        .b_en          (b_en),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [NUM_M-1:0] g;
        logic [NUM_S:0]   r;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq0[$];
    logic [31:0] mq1[$];

    int total = 0;
    int bad   = 0;

    // slave / master behaviour knobs
    int aw_delay = 0;
    int b_delay  = 0;
    int nbeats   = 1;
    bit early_w  = 1'b0;
    bit no_b     = 1'b0;

    // model state
    int               aw_cnt = 0;
    int               b_cnt = 0;
    int               beats_left = 0;
    bit               aw_seen = 1'b0;
    bit               pend_aw = 1'b0, pend_w = 1'b0, pend_b = 1'b0;
    logic [NUM_M-1:0] pend_g = '0;

    // per-test statistics
    int st_aw, st_w, st_b, st_busy, st_beats, st_txn, st_early;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        st_aw = 0; st_w = 0; st_b = 0; st_busy = 0;
        st_beats = 0; st_txn = 0; st_early = 0;
    endtask

    task automatic push_req(input int m, input logic [31:0] a);
        if (m == 0) mq0.push_back(a);
        else        mq1.push_back(a);
    endtask

    task automatic push_exp(input int m, input int slv);
        exp_t e;
        e.g = NUM_M'(1) << m;
        e.r = (NUM_S + 1)'(1) << slv;
        exp_q.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant_m), 0);
        chk({tag, "_route"}, 32'(route_slave), 0);
        chk({tag, "_en"}, {29'd0, aw_en, w_en, b_en}, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err_timeout), 0);
    endtask

    // One clock: retire the handshakes of the last edge, observe, drive.
    task automatic step();
        exp_t e;
        @(negedge ACLK);
        if (!ARESET) begin
            if (pend_aw) begin
                if (pend_g[0] && mq0.size() != 0) void'(mq0.pop_front());
                else if (pend_g[1] && mq1.size() != 0) void'(mq1.pop_front());
            end
            if (pend_w) begin beats_left--; st_beats++; end
            if (pend_b) st_txn++;
        end
        if (aw_en) st_aw++;
        if (w_en)  st_w++;
        if (b_en)  st_b++;
        if (busy)  st_busy++;

        if (aw_en && !aw_seen) begin
            aw_seen    = 1'b1;
            beats_left = nbeats;
            aw_cnt     = 0;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_aw", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_grant", 32'(grant_m), 32'(e.g));
                chk("sb_route", 32'(route_slave), 32'(e.r));
            end
        end
        if (!busy) aw_seen = 1'b0;
        if (aw_en) chk("w_en_in_addr", 32'(w_en), 0);

        aw_valid_m[0]    = (mq0.size() != 0);
        aw_valid_m[1]    = (mq1.size() != 0);
        aw_addr_m[31:0]  = (mq0.size() != 0) ? mq0[0] : 32'd0;
        aw_addr_m[63:32] = (mq1.size() != 0) ? mq1[0] : 32'd0;

        route_awready = aw_en && (aw_cnt >= aw_delay);
        if (aw_en) aw_cnt++;

        route_wvalid = aw_seen && (beats_left > 0) && (w_en || early_w);
        route_wlast  = (beats_left == 1);
        route_wready = w_en;
        if (aw_en && route_wvalid) st_early++;

        if (!b_en) b_cnt = 0;
        route_bvalid = b_en && !no_b && (b_cnt >= b_delay);
        route_bready = 1'b1;
        if (b_en) b_cnt++;

        pend_aw = aw_en && route_awready && ((aw_valid_m & grant_m) != '0);
        pend_g  = grant_m;
        pend_w  = w_en && route_wvalid && route_wready;
        pend_b  = b_en && route_bvalid && route_bready;
    endtask

    task automatic run_until_done(input int max_cyc, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(mq0.size() == 0 && mq1.size() == 0 && exp_q.size() == 0 && !busy)
                   && n < max_cyc);
        if (n >= max_cyc) chk({tag, "_cycle_bound"}, 0, 1);
    endtask

    initial begin
        int n;
        ARESET        = 1'b1;
        aw_valid_m    = '0;
        aw_addr_m     = '0;
        route_awready = 1'b0;
        route_wvalid  = 1'b0;
        route_wready  = 1'b0;
        route_wlast   = 1'b0;
        route_bvalid  = 1'b0;
        route_bready  = 1'b0;
        err_clr       = 1'b0;
        clear_stats();

        repeat (3) step();
        check_idle_outputs("rst_init");
        ARESET = 1'b0;

        // reset in the middle of DATA
        aw_delay = 1; nbeats = 8; b_delay = 0;
        push_req(0, 32'h1000_0040);
        push_exp(0, 1);
        n = 0;
        do begin step(); n++; end while (!w_en && n < 50);
        chk("rst_reach_data", 32'(w_en), 1);
        ARESET = 1'b1;
        mq0.delete(); mq1.delete(); exp_q.delete();
        beats_left = 0;
        step();
        check_idle_outputs("rst_mid_1");
        repeat (2) step();
        ARESET = 1'b0;
        step();
        check_idle_outputs("rst_mid_3");

        // single write, slave 2, awready after 2 cycles, 4 beats, late B
        clear_stats();
        aw_delay = 2; nbeats = 4; b_delay = 1;
        push_req(0, 32'h2000_0100);
        push_exp(0, 2);
        run_until_done(100, "single");
        chk("single_aw_cyc", st_aw, 3);
        chk("single_w_cyc", st_w, 4);
        chk("single_b_cyc", st_b, 2);
        chk("single_busy_cyc", st_busy, 10);
        chk("single_beats", st_beats, 4);
        chk("single_txn", st_txn, 1);
        check_idle_outputs("single_end");

        // contention from a fresh pointer: strict alternation m0,m1,...
        ARESET = 1'b1; step(); ARESET = 1'b0;
        clear_stats();
        aw_delay = 0; nbeats = 2; b_delay = 0;
        push_req(0, 32'h0000_0010); push_req(0, 32'h1000_0020); push_req(0, 32'h2000_0030);
        push_req(1, 32'h3000_0040); push_req(1, 32'h4000_0050); push_req(1, 32'h0000_0060);
        push_exp(0, 0); push_exp(1, 3); push_exp(0, 1);
        push_exp(1, 4); push_exp(0, 2); push_exp(1, 0);
        run_until_done(400, "contend");
        chk("contend_txn", st_txn, 6);
        chk("contend_beats", st_beats, 12);

        // unmapped address goes to the default slave and still completes
        clear_stats();
        nbeats = 2; b_delay = 1;
        push_req(1, 32'h8000_1234);
        push_exp(1, NUM_S);
        run_until_done(100, "unmapped");
        chk("unmapped_txn", st_txn, 1);
        chk("unmapped_beats", st_beats, 2);

        // W valid raised during ADDR must not be accepted early
        clear_stats();
        aw_delay = 3; nbeats = 4; b_delay = 0; early_w = 1'b1;
        push_req(0, 32'h4000_0000);
        push_exp(0, 4);
        run_until_done(100, "early_w");
        chk("early_w_seen", st_early, 4);
        chk("early_w_beats", st_beats, 4);
        chk("early_w_wcyc", st_w, 4);
        chk("early_w_txn", st_txn, 1);
        early_w = 1'b0;

`ifdef AXI_WR_TIMEOUT_EN
        // slave never answers B: watchdog aborts after TO_CYC RESP cycles
        clear_stats();
        aw_delay = 0; nbeats = 1; no_b = 1'b1;
        push_req(0, 32'h0000_1000);
        push_exp(0, 0);
        run_until_done(200, "timeout");
        chk("timeout_b_cyc", st_b, TO_CYC);
        chk("timeout_txn", st_txn, 0);
        chk("timeout_err", 32'(err_timeout), 1);
        chk("timeout_en", {29'd0, aw_en, w_en, b_en}, 0);
        err_clr = 1'b1; step(); err_clr = 1'b0; step();
        chk("timeout_err_clr", 32'(err_timeout), 0);
        no_b = 1'b0;
        clear_stats();
        push_req(1, 32'h3000_0000);
        push_exp(1, 3);
        run_until_done(100, "after_timeout");
        chk("after_timeout_txn", st_txn, 1);
        chk("after_timeout_err", 32'(err_timeout), 0);
`else
        err_clr = 1'b1; step(); err_clr = 1'b0; step();
        chk("err_tied_low", 32'(err_timeout), 0);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
